// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding selects and
// load-use hazard detection for a 5-stage MIPS datapath.
module id_ex_forward_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [REG_W-1:0]  ID_Rs,
   input  logic [REG_W-1:0]  ID_Rt,
   input  logic [REG_W-1:0]  ID_Rd,
   input  logic [DATA_W-1:0] ID_ReadData1,
   input  logic [DATA_W-1:0] ID_ReadData2,
   input  logic              ID_RegWrite,
   input  logic              ID_MemRead,
   input  logic              Flush,
   input  logic              EXMEM_RegWrite,
   input  logic [REG_W-1:0]  EXMEM_Rd,
   input  logic              MEMWB_RegWrite,
   input  logic [REG_W-1:0]  MEMWB_Rd,
   output logic [DATA_W-1:0] EX_ReadData1,
   output logic [DATA_W-1:0] EX_ReadData2,
   output logic [REG_W-1:0]  EX_Rs,
   output logic [REG_W-1:0]  EX_Rt,
   output logic [REG_W-1:0]  EX_Rd,
   output logic              EX_RegWrite,
   output logic              EX_MemRead,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              Stall,
   output logic [CNT_W-1:0]  StallCount
);

   localparam logic [1:0]       FWD_NONE  = 2'b00;
   localparam logic [1:0]       FWD_EXMEM = 2'b01;
   localparam logic [1:0]       FWD_MEMWB = 2'b10;
   localparam logic [REG_W-1:0] REG_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic bubble;

   // Forward select for one operand; the EX/MEM result is newer so it wins, $0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (EXMEM_RegWrite && (EXMEM_Rd != REG_ZERO) && (EXMEM_Rd == src))
         sel = FWD_EXMEM;
      else if (MEMWB_RegWrite && (MEMWB_Rd != REG_ZERO) && (MEMWB_Rd == src))
         sel = FWD_MEMWB;
      return sel;
   endfunction

   // Load-use hazard detection and operand forwarding selects.
   always_comb begin
      Stall    = EX_MemRead && (EX_Rd != REG_ZERO) &&
                 ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));
      ForwardA = fwd_sel(EX_Rs);
      ForwardB = fwd_sel(EX_Rt);
      bubble   = Flush || Stall;
   end

   // ID/EX register: squashed to an all-zero bubble on flush or load-use stall.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_RegWrite  <= 1'b0;
         EX_MemRead   <= 1'b0;
      end else if (bubble) begin
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_RegWrite  <= 1'b0;
         EX_MemRead   <= 1'b0;
      end else begin
         EX_ReadData1 <= ID_ReadData1;
         EX_ReadData2 <= ID_ReadData2;
         EX_Rs        <= ID_Rs;
         EX_Rt        <= ID_Rt;
         EX_Rd        <= ID_Rd;
         EX_RegWrite  <= ID_RegWrite;
         EX_MemRead   <= ID_MemRead;
      end
   end

   // Saturating count of stall cycles that were not overridden by a flush.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         StallCount <= '0;
      else if (Stall && !Flush && (StallCount != CNT_MAX))
         StallCount <= StallCount + CNT_W'(1);
   end

endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, merged with the EX-stage forwarding-select logic and load-use hazard detection.
- Registers the decoded operands and register numbers from ID.
- Generates the 2-bit select codes for the two 3:1 ALU-operand muxes in EX.
- Issues a one-cycle stall to the PC and IF/ID stage when a load-use hazard exists.

Parameters:
DATA_W, 32, operand width
REG_W, 5, register-number width
CNT_W, 16, width of stall-cycle performance counter

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
ID_Rs  in  REG_W  source register 1 number from decode
ID_Rt  in  REG_W  source register 2 number from decode
ID_Rd  in  REG_W  resolved destination register from decode
ID_ReadData1  in  DATA_W  register-file read port 1
ID_ReadData2  in  DATA_W  register-file read port 2
ID_RegWrite  in  1  instruction writes the register file
ID_MemRead  in  1  instruction is a load
Flush  in  1  squash the instruction entering EX (branch taken)
EXMEM_RegWrite  in  1  EX/MEM-stage instruction writes a register
EXMEM_Rd  in  REG_W  EX/MEM-stage destination register
MEMWB_RegWrite  in  1  MEM/WB-stage instruction writes a register
MEMWB_Rd  in  REG_W  MEM/WB-stage destination register
EX_ReadData1  out  DATA_W  registered operand 1 (mux input 00)
EX_ReadData2  out  DATA_W  registered operand 2 (mux input 00)
EX_Rs  out  REG_W  registered Rs
EX_Rt  out  REG_W  registered Rt
EX_Rd  out  REG_W  registered destination register
EX_RegWrite  out  1  registered RegWrite
EX_MemRead  out  1  registered MemRead
ForwardA  out  2  select for operand-A mux
ForwardB  out  2  select for operand-B mux
Stall  out  1  hold PC and IF/ID, this cycle
StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset:
  - Rst=1 asynchronously clears every registered output to 0: EX_* fields, StallCount.
  - With EX_Rs=EX_Rt=0, ForwardA=ForwardB=00 and Stall=0 during reset.
- Latency: ID_* values sampled at edge N appear on EX_* outputs after edge N, one cycle.
- Register load priority at each rising edge:
  - Flush=1: load bubble.
  - Else Stall=1: load bubble.
  - Else: load ID_* inputs.
  - Bubble = all EX_* fields 0, so RegWrite=0, MemRead=0, register numbers 0, data 0.
- Stall is combinational:
  - Stall = EX_MemRead & (EX_Rd != 0) & ((EX_Rd == ID_Rs) | (EX_Rd == ID_Rt)).
  - A bubble clears EX_MemRead, so a stall lasts exactly one cycle per load-use pair.
  - Stall is not masked by Flush; the upstream stage gives Flush priority.
- ForwardA is combinational from the registered EX_Rs and live EXMEM/MEMWB inputs:
  - 01 if EXMEM_RegWrite & EXMEM_Rd != 0 & EXMEM_Rd == EX_Rs.
  - Else 10 if MEMWB_RegWrite & MEMWB_Rd != 0 & MEMWB_Rd == EX_Rs.
  - Else 00.
- ForwardB: same rules using EX_Rt.
- Encoding 11 is never produced.
- Register $0 never forwards and never causes a stall.
- When EXMEM and MEMWB both match, EXMEM (the newer value) wins.
- StallCount:
  - Increments at an edge where Stall=1 and Flush=0.
  - Saturates at 2^CNT_W−1 and holds there.
  - Cleared only by Rst.
- Rst asserted mid-operation discards any in-flight instruction and pending stall immediately; there is no recovery state.

Test Plan:
- Reset: Rst=1 with ID_* non-zero → all EX_* = 0, ForwardA/B = 00, Stall = 0, StallCount = 0. Release Rst, then one edge → EX_* mirrors ID_*.
- EX/MEM forward: EX_Rs=8; EXMEM_RegWrite=1, EXMEM_Rd=8; MEMWB_RegWrite=1, MEMWB_Rd=8 → ForwardA = 01 (EXMEM priority). Drop EXMEM_RegWrite → ForwardA = 10.
- $0 guard: EX_Rt=0, EXMEM_Rd=0, EXMEM_RegWrite=1 → ForwardB = 00. Load in EX with EX_Rd=0 and ID_Rs=0 → Stall = 0.
- Load-use: lw writes $9, next ID_Rt=9 → Stall = 1 for exactly one cycle. The next edge loads a bubble (EX_RegWrite=0). StallCount increments by 1. The following cycle, Stall = 0 and the dependent instruction enters EX with ForwardB = 10 once the lw reaches MEM/WB.
- Flush vs stall: Stall=1 and Flush=1 at the same edge → bubble loaded, StallCount unchanged.
- Saturation: CNT_W=2; force 5 stall cycles → StallCount sequence 1, 2, 3, 3, 3.
